// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDATA,
        DONE
    } arb_state_t;

    typedef enum logic {
        FETCH,
        DATA
    } arb_port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes and the Avalon-MM master port shared by the arbiter.
interface mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_done;
    logic [31:0] d_rdata;

    logic        err;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_be,
        input  avm_waitrequest, avm_readdata,
        output i_done, i_rdata, d_done, d_rdata, err,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

    modport slave (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_be,
        output avm_waitrequest, avm_readdata,
        input  i_done, i_rdata, d_done, d_rdata, err,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM port between instruction fetch and data access.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrates and latches the winner's fields
//   ISSUE | strobe on the bus, held through waitrequest, stall timer running
//   RDATA | strobe low, readdata captured for the granted port
//   DONE  | one-cycle done (and err on timeout) to the granted port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_t       state;
    arb_port_t        grant;
    arb_port_t        last_grant;
    logic [CNT_W-1:0] stall_cnt;
    logic             we_q;
    logic             pick_data;
    logic             timed_out;

    always_comb begin
        pick_data = 1'b0;
        if (bus.i_req && bus.d_req) begin
            pick_data = (last_grant == FETCH);
        end else begin
            pick_data = bus.d_req;
        end
    end

    assign timed_out = (TIMEOUT != 0) && (stall_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            grant              <= FETCH;
            last_grant         <= DATA;
            stall_cnt          <= '0;
            we_q               <= 1'b0;
            bus.i_done         <= 1'b0;
            bus.i_rdata        <= '0;
            bus.d_done         <= 1'b0;
            bus.d_rdata        <= '0;
            bus.err            <= 1'b0;
            bus.avm_address    <= '0;
            bus.avm_read       <= 1'b0;
            bus.avm_write      <= 1'b0;
            bus.avm_writedata  <= '0;
            bus.avm_byteenable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        if (pick_data) begin
                            grant              <= DATA;
                            last_grant         <= DATA;
                            bus.avm_address    <= {bus.d_addr[31:2], 2'b00};
                            bus.avm_writedata  <= bus.d_wdata;
                            bus.avm_byteenable <= bus.d_be;
                            we_q               <= bus.d_we;
                            bus.avm_write      <= bus.d_we;
                            bus.avm_read       <= ~bus.d_we;
                        end else begin
                            grant              <= FETCH;
                            last_grant         <= FETCH;
                            bus.avm_address    <= {bus.i_addr[31:2], 2'b00};
                            bus.avm_writedata  <= '0;
                            bus.avm_byteenable <= 4'hF;
                            we_q               <= 1'b0;
                            bus.avm_write      <= 1'b0;
                            bus.avm_read       <= 1'b1;
                        end
                        stall_cnt <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.avm_waitrequest) begin
                        if (timed_out) begin
                            // Abort: report completion with err and a zeroed rdata.
                            bus.avm_read  <= 1'b0;
                            bus.avm_write <= 1'b0;
                            bus.err       <= 1'b1;
                            if (grant == FETCH) begin
                                bus.i_done  <= 1'b1;
                                bus.i_rdata <= '0;
                            end else begin
                                bus.d_done  <= 1'b1;
                                bus.d_rdata <= '0;
                            end
                            state <= DONE;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        bus.avm_read  <= 1'b0;
                        bus.avm_write <= 1'b0;
                        if (we_q) begin
                            bus.d_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (grant == FETCH) begin
                        bus.i_done  <= 1'b1;
                        bus.i_rdata <= bus.avm_readdata;
                    end else begin
                        bus.d_done  <= 1'b1;
                        bus.d_rdata <= bus.avm_readdata;
                    end
                    state <= DONE;
                end
                DONE: begin
                    bus.i_done <= 1'b0;
                    bus.d_done <= 1'b0;
                    bus.err    <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default-timeout instance plus a TIMEOUT=4 instance.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   overlap = 0;

    mem_arbiter_if b ();
    mem_arbiter_if t ();

    mem_arbiter u_dut (.clk(clk), .reset(reset), .bus(b));
    mem_arbiter #(.TIMEOUT(4)) u_dut_to (.clk(clk), .reset(reset), .bus(t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((b.avm_read && b.avm_write) || (t.avm_read && t.avm_write)) overlap++;
    end

    task automatic wait_strobe(output logic [31:0] addr, output logic rd, output bit ok);
        ok = 1'b0;
        addr = '0;
        rd = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b.avm_read || b.avm_write) begin
                addr = b.avm_address;
                rd = b.avm_read;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output logic fet, output bit ok);
        ok = 1'b0;
        fet = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b.i_done || b.d_done) begin
                fet = b.i_done;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        b.i_req = 0; b.i_addr = '0; b.d_req = 0; b.d_addr = '0; b.d_we = 0; b.d_wdata = '0; b.d_be = '0;
        b.avm_waitrequest = 0; b.avm_readdata = '0;
        t.i_req = 0; t.i_addr = '0; t.d_req = 0; t.d_addr = '0; t.d_we = 0; t.d_wdata = '0; t.d_be = '0;
        t.avm_waitrequest = 0; t.avm_readdata = '0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({b.i_done, b.i_rdata, b.d_done, b.d_rdata, b.err, b.avm_address, b.avm_read,
             b.avm_write, b.avm_writedata, b.avm_byteenable} !== 137'd0) begin
            bad++;
            $display("FAIL reset_outputs got i_done=%b d_done=%b err=%b rd=%b wr=%b addr=%h exp all zero",
                     b.i_done, b.d_done, b.err, b.avm_read, b.avm_write, b.avm_address);
        end
        reset = 1'b1;
    endtask

    task automatic test_lone_fetch();
        @(posedge clk); #1;
        b.i_req = 1; b.i_addr = 32'hBFC0_0003; b.avm_waitrequest = 0; b.avm_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if (b.avm_read !== 1'b0) begin bad++; $display("FAIL fetch_c0_read got=%b exp=0", b.avm_read); end
        @(negedge clk);
        total++;
        if ({b.avm_read, b.avm_write, b.avm_address, b.avm_byteenable} !== {1'b1, 1'b0, 32'hBFC0_0000, 4'hF}) begin
            bad++;
            $display("FAIL fetch_c1_bus got rd=%b wr=%b addr=%h be=%h exp rd=1 wr=0 addr=bfc00000 be=f",
                     b.avm_read, b.avm_write, b.avm_address, b.avm_byteenable);
        end
        @(posedge clk); #1; b.avm_readdata = 32'h1234_5678;
        @(negedge clk);
        total++;
        if ({b.avm_read, b.i_done} !== 2'b00) begin
            bad++; $display("FAIL fetch_c2 got rd=%b i_done=%b exp 0 0", b.avm_read, b.i_done);
        end
        @(posedge clk); #1; b.avm_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if ({b.i_done, b.i_rdata, b.err, b.d_done} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL fetch_c3_done got i_done=%b i_rdata=%h err=%b d_done=%b exp 1 12345678 0 0",
                     b.i_done, b.i_rdata, b.err, b.d_done);
        end
        @(posedge clk); #1; b.i_req = 0;
        @(negedge clk);
        total++;
        if ({b.i_done, b.i_rdata} !== {1'b0, 32'h1234_5678}) begin
            bad++; $display("FAIL fetch_c4_hold got i_done=%b i_rdata=%h exp 0 12345678", b.i_done, b.i_rdata);
        end
    endtask

    task automatic test_store_stall();
        @(posedge clk); #1;
        b.d_req = 1; b.d_we = 1; b.d_be = 4'b0100; b.d_wdata = 32'h0000_00AA; b.d_addr = 32'h0000_1006;
        b.avm_waitrequest = 1;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                @(posedge clk); #1; b.avm_waitrequest = 0;
            end
            @(negedge clk);
            total++;
            if ({b.avm_write, b.avm_read, b.avm_address, b.avm_writedata, b.avm_byteenable, b.d_done} !==
                {1'b1, 1'b0, 32'h0000_1004, 32'h0000_00AA, 4'b0100, 1'b0}) begin
                bad++;
                $display("FAIL store_c%0d_bus got wr=%b rd=%b addr=%h wd=%h be=%b done=%b exp 1 0 00001004 000000aa 0100 0",
                         k, b.avm_write, b.avm_read, b.avm_address, b.avm_writedata, b.avm_byteenable, b.d_done);
            end
        end
        @(negedge clk);
        total++;
        if ({b.d_done, b.avm_write, b.err, b.i_done} !== 4'b1000) begin
            bad++; $display("FAIL store_c5_done got d_done=%b wr=%b err=%b i_done=%b exp 1 0 0 0",
                            b.d_done, b.avm_write, b.err, b.i_done);
        end
        @(posedge clk); #1; b.d_req = 0; b.d_we = 0;
        @(negedge clk);
        total++;
        if (b.d_done !== 1'b0) begin bad++; $display("FAIL store_c6_pulse got d_done=%b exp 0", b.d_done); end
    endtask

    task automatic test_round_robin();
        logic [31:0] a;
        logic        rd;
        logic        f;
        bit          ok;
        bit          ok2;
        @(posedge clk); #1;
        b.avm_readdata = 32'h0000_0001;
        b.i_req = 1; b.i_addr = 32'h0000_0100;
        b.d_req = 1; b.d_we = 1; b.d_addr = 32'h0000_0204; b.d_wdata = 32'h55; b.d_be = 4'hF;
        wait_strobe(a, rd, ok); wait_done(f, ok2);
        total++;
        if ({ok, ok2, a, rd, f} !== {2'b11, 32'h0000_0100, 1'b1, 1'b1}) begin
            bad++; $display("FAIL rr_grant1 got ok=%b%b addr=%h rd=%b fetch=%b exp 11 00000100 1 1", ok, ok2, a, rd, f);
        end
        @(posedge clk); #1; b.i_req = 0;
        wait_strobe(a, rd, ok);
        @(posedge clk); #1; b.i_req = 1; b.i_addr = 32'h0000_0108;
        wait_done(f, ok2);
        total++;
        if ({ok, ok2, a, rd, f} !== {2'b11, 32'h0000_0204, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rr_grant2 got ok=%b%b addr=%h rd=%b fetch=%b exp 11 00000204 0 0", ok, ok2, a, rd, f);
        end
        @(posedge clk); #1; b.d_req = 0;
        wait_strobe(a, rd, ok); wait_done(f, ok2);
        total++;
        if ({ok, ok2, a, rd, f} !== {2'b11, 32'h0000_0108, 1'b1, 1'b1}) begin
            bad++; $display("FAIL rr_grant3 got ok=%b%b addr=%h rd=%b fetch=%b exp 11 00000108 1 1", ok, ok2, a, rd, f);
        end
        @(posedge clk); #1; b.i_req = 0;
        @(posedge clk); #1;
        b.i_req = 1; b.i_addr = 32'h0000_010C;
        b.d_req = 1; b.d_addr = 32'h0000_0208;
        wait_strobe(a, rd, ok); wait_done(f, ok2);
        total++;
        if ({ok, ok2, a, f} !== {2'b11, 32'h0000_0208, 1'b0}) begin
            bad++; $display("FAIL rr_tie_after_fetch got ok=%b%b addr=%h fetch=%b exp 11 00000208 0", ok, ok2, a, f);
        end
        @(posedge clk); #1; b.d_req = 0;
        wait_strobe(a, rd, ok); wait_done(f, ok2);
        total++;
        if ({ok, ok2, a, f} !== {2'b11, 32'h0000_010C, 1'b1}) begin
            bad++; $display("FAIL rr_grant5 got ok=%b%b addr=%h fetch=%b exp 11 0000010c 1", ok, ok2, a, f);
        end
        @(posedge clk); #1; b.i_req = 0; b.d_we = 0;
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL rr_strobe_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic t_load(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        t.d_req = 1; t.d_we = 0; t.d_addr = addr; t.d_be = 4'hF; t.avm_waitrequest = 0;
        t.avm_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({t.avm_read, t.avm_address} !== {1'b1, addr[31:2], 2'b00}) begin
            bad++; $display("FAIL to_load_issue got rd=%b addr=%h exp rd=1 addr=%h", t.avm_read, t.avm_address, addr);
        end
        @(posedge clk); #1; t.avm_readdata = data;
        @(negedge clk);
        @(posedge clk); #1; t.avm_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if ({t.d_done, t.d_rdata, t.err} !== {1'b1, data, 1'b0}) begin
            bad++; $display("FAIL to_load_done got d_done=%b d_rdata=%h err=%b exp 1 %h 0", t.d_done, t.d_rdata, t.err, data);
        end
        @(posedge clk); #1; t.d_req = 0;
    endtask

    task automatic test_timeout();
        t_load(32'h0000_0010, 32'hCAFE_F00D);
        @(posedge clk); #1;
        t.d_req = 1; t.d_we = 0; t.d_addr = 32'h0000_0300; t.avm_waitrequest = 1;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if ({t.avm_read, t.d_done, t.err} !== 3'b100) begin
                bad++; $display("FAIL timeout_c%0d got rd=%b d_done=%b err=%b exp 1 0 0", k, t.avm_read, t.d_done, t.err);
            end
        end
        @(negedge clk);
        total++;
        if ({t.avm_read, t.d_done, t.err, t.d_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            bad++; $display("FAIL timeout_done got rd=%b d_done=%b err=%b d_rdata=%h exp 0 1 1 00000000",
                            t.avm_read, t.d_done, t.err, t.d_rdata);
        end
        @(posedge clk); #1; t.d_req = 0; t.avm_waitrequest = 0;
        @(negedge clk);
        total++;
        if ({t.d_done, t.err} !== 2'b00) begin
            bad++; $display("FAIL timeout_err_clear got d_done=%b err=%b exp 0 0", t.d_done, t.err);
        end
        t_load(32'h0000_0022, 32'h600D_0001);
    endtask

    task automatic test_reset_mid_issue();
        logic [31:0] a;
        logic        rd;
        logic        f;
        bit          ok;
        bit          ok2;
        @(posedge clk); #1;
        b.i_req = 1; b.i_addr = 32'h0000_0400; b.avm_waitrequest = 1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        total++;
        if (b.avm_read !== 1'b1) begin bad++; $display("FAIL midrst_stalled got rd=%b exp 1", b.avm_read); end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({b.i_done, b.i_rdata, b.d_done, b.d_rdata, b.err, b.avm_address, b.avm_read,
             b.avm_write, b.avm_writedata, b.avm_byteenable} !== 137'd0) begin
            bad++;
            $display("FAIL midrst_outputs got rd=%b wr=%b addr=%h i_rdata=%h d_rdata=%h exp all zero",
                     b.avm_read, b.avm_write, b.avm_address, b.i_rdata, b.d_rdata);
        end
        b.i_req = 0; b.avm_waitrequest = 0; b.avm_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        b.i_req = 1; b.i_addr = 32'h0000_0500;
        b.d_req = 1; b.d_we = 0; b.d_addr = 32'h0000_0600;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({b.avm_read, b.avm_address, b.avm_byteenable} !== {1'b1, 32'h0000_0500, 4'hF}) begin
            bad++; $display("FAIL midrst_fetch_first got rd=%b addr=%h be=%h exp 1 00000500 f",
                            b.avm_read, b.avm_address, b.avm_byteenable);
        end
        @(posedge clk); #1; b.avm_readdata = 32'h0000_0777;
        @(negedge clk);
        @(posedge clk); #1; b.avm_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if ({b.i_done, b.i_rdata, b.d_done} !== {1'b1, 32'h0000_0777, 1'b0}) begin
            bad++; $display("FAIL midrst_fetch_done got i_done=%b i_rdata=%h d_done=%b exp 1 00000777 0",
                            b.i_done, b.i_rdata, b.d_done);
        end
        @(posedge clk); #1; b.i_req = 0;
        wait_strobe(a, rd, ok); wait_done(f, ok2);
        total++;
        if ({ok, ok2, a, rd, f, b.d_rdata} !== {2'b11, 32'h0000_0600, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL midrst_data_next got ok=%b%b addr=%h rd=%b fetch=%b d_rdata=%h exp 11 00000600 1 0 deadbeef",
                            ok, ok2, a, rd, f, b.d_rdata);
        end
        @(posedge clk); #1; b.d_req = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store_stall();
        test_round_robin();
        test_timeout();
        test_reset_mid_issue();
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL final_strobe_overlap got=%0d exp=0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential bus controller that shares the CPU's single Avalon-MM memory port between the instruction-fetch requester and the data (load/store) requester. It arbitrates round-robin on conflict, registers the winning request onto the bus, holds it through `waitrequest` stalls, and captures read data one cycle after acceptance. It returns a one-cycle `done` pulse to the winner, and aborts with an error after a configurable stall timeout.

## Interface
- `TIMEOUT`, 256: maximum cycles a request may be stalled by `waitrequest`; 0 disables the timeout.
- `clk  in  1  system clock, rising edge`
- `reset  in  1  asynchronous, active-low reset`
- `i_req  in  1  fetch request; held with its fields until `i_done``
- `i_addr  in  32  fetch byte address`
- `i_done  out  1  one-cycle completion pulse for fetch`
- `i_rdata  out  32  fetch read data; valid while `i_done``
- `d_req  in  1  data request; held until `d_done``
- `d_addr  in  32  data byte address`
- `d_we  in  1  1 = write, 0 = read`
- `d_wdata  in  32  store data`
- `d_be  in  4  byte enables`
- `d_done  out  1  one-cycle completion pulse for data`
- `d_rdata  out  32  load read data; valid while `d_done``
- `err  out  1  asserted with `done` when a transaction timed out`
- `avm_address  out  32  bus address, always word aligned ([1:0] = 0)`
- `avm_read  out  1  bus read strobe`
- `avm_write  out  1  bus write strobe`
- `avm_writedata  out  32  bus write data`
- `avm_byteenable  out  4  bus byte enables (fetch always 4'b1111)`
- `avm_waitrequest  in  1  slave stall`
- `avm_readdata  in  32  slave read data, valid one cycle after acceptance`

## Operation
- FSM states: IDLE, ISSUE, RDATA, DONE.
- **IDLE:**
  - No request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the port not granted last (`last_grant`). Reset value of `last_grant` is DATA, so fetch wins the first tie.
  - On grant, latch address (with [1:0] cleared), we, wdata and be into registers; update `last_grant`; go to ISSUE.
- **ISSUE:**
  - `avm_read` or `avm_write` is high with the latched fields.
  - `avm_waitrequest` = 1: stay in ISSUE and increment the stall counter.
  - `avm_waitrequest` = 0 on a write: go to DONE.
  - `avm_waitrequest` = 0 on a read: go to RDATA.
- **RDATA:** strobes low; capture `avm_readdata` into the granted port's rdata register; go to DONE.
- **DONE:** the granted port's `done` is 1 for exactly one cycle; next state is IDLE.
- Requester obligations:
  - A requester must drop `req` in the cycle after its `done`.
  - The arbiter does not mask a `req` that is still high in IDLE; it treats it as a new request.
- Timeout:
  - If `TIMEOUT` ≠ 0 and the stall counter reaches `TIMEOUT-1` while `waitrequest` = 1, strobes drop and the FSM goes to DONE with `err` = 1.
  - rdata is 0 on a timeout.
  - The counter clears on every entry to ISSUE.
  - Counter width is $clog2(TIMEOUT+1).
- Only one transaction is outstanding at any time. There is no pipelining.

## Timing
- **Reset:** all outputs 0, state IDLE, `last_grant` = DATA, counter 0. Reset takes effect immediately (asynchronous), including mid-transaction; bus strobes drop in the same cycle.
- **Read, zero stall:**
  - req in cycle 0
  - `avm_read` in cycle 1
  - RDATA in cycle 2 (readdata sampled at the end of cycle 2)
  - `done`/rdata in cycle 3
  - IDLE in cycle 4
  - Each stall cycle adds 1.
- **Write, zero stall:**
  - req in cycle 0
  - `avm_write` in cycle 1
  - `done` in cycle 2
  - IDLE in cycle 3
- Bus outputs are registered and stay constant throughout ISSUE.
- `i_rdata`/`d_rdata` hold their value after `done` until the next completion for that port.
- A request that arrives during ISSUE, RDATA or DONE waits for IDLE.
- `err` is valid only with `done`; it is 0 otherwise.

## Structure
- Package `mem_arbiter_pkg`: state enum `arb_state_t` (IDLE, ISSUE, RDATA, DONE) and port-id enum `arb_port_t` (FETCH, DATA).
- Single module with no sub-modules; the timeout counter is inline.

## Test plan
- **Lone fetch:** `i_req`, `i_addr`=32'hBFC0_0003, slave waitrequest 0, readdata 32'h1234_5678 →
  - `avm_address`=32'hBFC0_0000, `avm_byteenable`=4'hF
  - `i_done` with `i_rdata`=32'h1234_5678 in cycle 3
  - `err`=0
- **Store with stall:** `d_we`=1, `d_be`=4'b0100, `d_wdata`=32'hAA, waitrequest high for 3 cycles →
  - `avm_write` is high for 4 cycles with stable fields
  - `d_done` in cycle 5
- **Simultaneous requests twice:** `i_req` and `d_req` both held →
  - grant order after reset is FETCH, DATA, FETCH
  - `avm_read` never asserts in the same cycle as `avm_write`
- **Timeout:** `TIMEOUT`=4, waitrequest stuck high on a load →
  - strobe drops after 4 ISSUE cycles
  - `d_done`=1, `err`=1, `d_rdata`=0
  - the next request completes normally
- **Reset mid-ISSUE:** `reset` low during a stalled read →
  - `avm_read` goes to 0 in the same cycle, all outputs 0
  - after release, a fetch completes with the normal 3-cycle latency
